dmem_access_ctrl: RTL

- Load/store sequencer between the core's memory stage and the single-port byte-lane data memory.
- Accepts one RV32 load/store request at a time.
- Splits any access the memory cannot perform natively into a sequence of legal memory operations:
  - a misaligned word;
  - a halfword at byte offset 3;
  - any load that crosses a word boundary.
- Returns sign/zero-extended load data and a completion pulse.

---
 rtl/dmem_access_ctrl_pkg.sv | 33 +++
 rtl/dmem_access_ctrl_if.sv | 33 +++
 rtl/dmem_access_ctrl_load_extend.sv | 30 +++
 rtl/dmem_access_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the data-memory
// load/store sequencer.
package dmem_pkg;

    localparam logic [1:0] STR_B  = 2'b00;
    localparam logic [1:0] STR_HW = 2'b01;
    localparam logic [1:0] STR_W  = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, LD0, LD1, ST, RESP} state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 < 3'd3;
        else
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Access size in bytes, taken from the low funct3 bits.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and data-memory signals of the load/store sequencer.
// slave is the controller's view; master is the core-plus-memory view.
interface dmem_access_ctrl_if #(parameter int ADDR_W = 9);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_din;
    logic              mem_we;
    logic [1:0]        mem_write_strobe;
    logic [31:0]       mem_rd_dout;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we, mem_write_strobe
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we, mem_write_strobe
    );

endinterface

// File: rtl/dmem_access_ctrl_load_extend.sv
// Picks the load bytes out of two consecutive memory words starting at the
// byte offset, then sign- or zero-extends them according to funct3.
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0][7:0] pair;
    logic [31:0]     data;

    always_comb begin
        pair = {hi_word, lo_word};
        data = '0;
        for (int k = 0; k < 4; k++)
            data[8*k +: 8] = pair[3'(offset) + 3'(k)];
        case (funct3)
            F3_B:    rdata = {{24{data[7]}}, data[7:0]};
            F3_H:    rdata = {{16{data[15]}}, data[15:0]};
            F3_BU:   rdata = {24'h0, data[7:0]};
            F3_HU:   rdata = {16'h0, data[15:0]};
            default: rdata = data;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer: splits accesses the byte-lane memory cannot do natively
// into legal word reads or byte writes, and returns extended load data.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH * 4)
) (
    input logic clk,
    input logic rst,
    dmem_access_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(DEPTH * 4 - 1);
    localparam logic [ADDR_W-3:0] LAST_WORD = (ADDR_W - 2)'(DEPTH - 1);

    state_t            state;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [1:0]        cnt;
    logic [1:0]        last_cnt;
    logic [31:0]       lo_q;
    logic [31:0]       lo_sel;
    logic [31:0]       ext_data;
    logic              crossing;
    logic              split;
    logic [ADDR_W-1:0] next_word_addr;
    logic [ADDR_W-1:0] next_byte_addr;

    always_comb begin
        lo_sel   = (state == LD0) ? bus.mem_rd_dout : lo_q;
        crossing = (4'(off_q) + 4'(access_size(f3_q))) > 4'd4;
        split    = ((bus.req_funct3 == F3_H) && (bus.req_addr[1:0] == 2'd3)) ||
                   ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'd0));
        next_word_addr = (bus.mem_rd_addr[ADDR_W-1:2] == LAST_WORD) ? '0 :
                         {bus.mem_rd_addr[ADDR_W-1:2] + 1'b1, 2'b00};
        next_byte_addr = (bus.mem_wr_addr == LAST_BYTE) ? '0 : bus.mem_wr_addr + 1'b1;
    end

    load_extend u_load_extend (
        .lo_word (lo_sel),
        .hi_word (bus.mem_rd_dout),
        .offset  (off_q),
        .funct3  (f3_q),
        .rdata   (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            off_q                <= '0;
            f3_q                 <= '0;
            cnt                  <= '0;
            last_cnt             <= '0;
            lo_q                 <= '0;
            bus.req_ready        <= 1'b1;
            bus.rsp_valid        <= 1'b0;
            bus.rsp_rdata        <= '0;
            bus.rsp_err          <= 1'b0;
            bus.mem_rd_addr      <= '0;
            bus.mem_wr_addr      <= '0;
            bus.mem_wr_din       <= '0;
            bus.mem_we           <= 1'b0;
            bus.mem_write_strobe <= STR_B;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    bus.req_ready <= 1'b0;
                    f3_q          <= bus.req_funct3;
                    off_q         <= bus.req_addr[1:0];
                    cnt           <= '0;
                    if (!f3_legal(bus.req_we, bus.req_funct3)) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end else if (bus.req_we) begin
                        state           <= ST;
                        bus.mem_we      <= 1'b1;
                        bus.mem_wr_addr <= bus.req_addr;
                        bus.mem_wr_din  <= bus.req_wdata;
                        // Legal store funct3 values 0..2 coincide with the native strobe codes.
                        bus.mem_write_strobe <= split ? STR_B : bus.req_funct3[1:0];
                        last_cnt <= !split ? 2'd0 : (bus.req_funct3 == F3_H) ? 2'd1 : 2'd3;
                    end else begin
                        state           <= LD0;
                        bus.mem_rd_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
                LD0: begin
                    lo_q <= bus.mem_rd_dout;
                    if (crossing) begin
                        state           <= LD1;
                        bus.mem_rd_addr <= next_word_addr;
                    end else begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= ext_data;
                    end
                end
                LD1: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= ext_data;
                end
                ST: if (cnt == last_cnt) begin
                    state                <= RESP;
                    bus.mem_we           <= 1'b0;
                    bus.mem_write_strobe <= STR_B;
                    bus.rsp_valid        <= 1'b1;
                end else begin
                    cnt             <= cnt + 2'd1;
                    bus.mem_wr_addr <= next_byte_addr;
                    bus.mem_wr_din  <= {8'h00, bus.mem_wr_din[31:8]};
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
